// File: rtl/hs_pkg.sv
// Shared definitions for the handshake synchronizer and its receive FIFO.
package hs_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    typedef logic [31:0] word_cnt_t;
    typedef logic [15:0] drop_cnt_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hs_rx_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module hs_rx_fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_rx_fifo.sv
// Receive FIFO behind the handshake synchronizer with dbusy backpressure.
// Define HS_RX_FIFO_STATS_EN to add the rx_words/drop_words statistics outputs.
module hs_rx_fifo
    import hs_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AW         = clog2(DEPTH),
    parameter int unsigned BUSY_LEVEL = DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dvalid,
    input  logic [WIDTH-1:0] din,
    output logic             dbusy,
    input  logic             flush,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [AW:0]      count,
    output logic             overflow
`ifdef HS_RX_FIFO_STATS_EN
    ,
    output logic [31:0]      rx_words,
    output logic [15:0]      drop_words
`endif
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          full, rd_en, wr_en, drop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign rd_en = m_valid && m_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en = dvalid && (!full || rd_en) && !flush;
    assign drop  = dvalid && full && !rd_en && !flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count_d = count_q + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    hs_rx_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (din),
        .raddr (rd_ptr_q),
        .rdata (m_data)
    );

    assign m_valid  = (count_q != '0);
    assign dbusy    = (count_q >= (AW+1)'(BUSY_LEVEL));
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef HS_RX_FIFO_STATS_EN
    word_cnt_t rx_words_q;
    drop_cnt_t drop_words_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rx_words_q   <= '0;
            drop_words_q <= '0;
        end else begin
            if (wr_en && (rx_words_q != '1)) begin
                rx_words_q <= rx_words_q + 32'd1;
            end
            if (drop && (drop_words_q != '1)) begin
                drop_words_q <= drop_words_q + 16'd1;
            end
        end
    end

    assign rx_words   = rx_words_q;
    assign drop_words = drop_words_q;
`endif

endmodule

// File: tb/tb_hs_rx_fifo.sv
// Self-checking bench for hs_rx_fifo: directed steps plus randomized traffic against a queue model.
module tb_hs_rx_fifo;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 4;
    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dvalid = 1'b0;
    logic [W-1:0]  din = '0;
    logic          dbusy;
    logic          flush = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [W-1:0]  m_data;
    logic [AW:0]   count;
    logic          overflow;

    logic          dvalid2 = 1'b0;
    logic [W-1:0]  din2 = '0;
    logic          dbusy2;
    logic          m_valid2;
    logic          m_ready2 = 1'b0;
    logic [W-1:0]  m_data2;
    logic [AW:0]   count2;
    logic          overflow2;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mq[$];
    bit           movf = 1'b0;

    always #5 clk = ~clk;

    hs_rx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dvalid   (dvalid),
        .din      (din),
        .dbusy    (dbusy),
        .flush    (flush),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .overflow (overflow)
    );

    hs_rx_fifo #(.WIDTH(W), .DEPTH(D), .BUSY_LEVEL(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .dvalid   (dvalid2),
        .din      (din2),
        .dbusy    (dbusy2),
        .flush    (1'b0),
        .m_valid  (m_valid2),
        .m_ready  (m_ready2),
        .m_data   (m_data2),
        .count    (count2),
        .overflow (overflow2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: the FIFO as a queue of words plus a sticky overflow bit.
    task automatic tick();
        bit rd;
        if (!rst_n || flush) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            rd = (mq.size() != 0) && m_ready;
            if (dvalid) begin
                if (mq.size() < D || rd) mq.push_back(din);
                else movf = 1'b1;
            end
            if (rd) void'(mq.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(mq.size()));
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(mq.size() != 0));
        chk({tag, ".dbusy"}, 64'(dbusy), 64'(mq.size() >= D));
        chk({tag, ".overflow"}, 64'(overflow), 64'(movf));
        if (mq.size() != 0) chk({tag, ".m_data"}, 64'(m_data), 64'(mq[0]));
    endtask

    task automatic drive(input bit dv, input logic [W-1:0] d, input bit rdy, input bit fl);
        dvalid  = dv;
        din     = d;
        m_ready = rdy;
        flush   = fl;
        tick();
        dvalid  = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        // Reset held for two edges
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.m_valid", 64'(m_valid), 64'd0);
        chk("rst.dbusy", 64'(dbusy), 64'd0);
        chk("rst.overflow", 64'(overflow), 64'd0);

        // Fill with m_ready low, then drain in order
        for (int i = 0; i < 4; i++) drive(1'b1, W'(32'hA0 + i), 1'b0, 1'b0);
        chk("fill.count", 64'(count), 64'd4);
        chk("fill.dbusy", 64'(dbusy), 64'd1);
        chk("fill.m_data", 64'(m_data), 64'hA0);
        for (int i = 0; i < 4; i++) begin
            chk("drain.m_data", 64'(m_data), 64'(32'hA0 + i));
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain.m_valid", 64'(m_valid), 64'd0);

        // Pointer wrap
        for (int i = 0; i < 3; i++) drive(1'b1, W'(32'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, W'(32'hB0 + i), 1'b0, 1'b0);
        chk("wrap.count", 64'(count), 64'd4);
        check_all("wrap");

        // Full with no read: word dropped, overflow sticky
        drive(1'b1, W'(32'hDEAD), 1'b0, 1'b0);
        chk("ovf.overflow", 64'(overflow), 64'd1);
        chk("ovf.count", 64'(count), 64'd4);
        chk("ovf.m_data", 64'(m_data), 64'hB0);
        // Full with coincident read: word accepted
        drive(1'b1, W'(32'hDEAD), 1'b1, 1'b0);
        chk("fullrd.count", 64'(count), 64'd4);
        chk("fullrd.overflow", 64'(overflow), 64'd1);
        chk("fullrd.m_data", 64'(m_data), 64'hB1);
        for (int i = 0; i < 4; i++) begin
            check_all("ovfdrain");
            drive(1'b0, '0, 1'b1, 1'b0);
        end
        chk("ovfdrain.m_valid", 64'(m_valid), 64'd0);

        // Flush with a coincident write clears overflow and discards the word
        drive(1'b1, W'(32'h55), 1'b0, 1'b1);
        chk("flush.count", 64'(count), 64'd0);
        chk("flush.overflow", 64'(overflow), 64'd0);
        chk("flush.m_valid", 64'(m_valid), 64'd0);

        // Simultaneous write and read at count=2
        drive(1'b1, W'(32'h11), 1'b0, 1'b0);
        drive(1'b1, W'(32'h22), 1'b0, 1'b0);
        drive(1'b1, W'(32'h33), 1'b1, 1'b0);
        chk("simul.count", 64'(count), 64'd2);
        chk("simul.m_data", 64'(m_data), 64'h22);

        // Flush on a full FIFO with a would-be overflow word
        drive(1'b1, W'(32'h44), 1'b0, 1'b0);
        drive(1'b1, W'(32'h66), 1'b0, 1'b0);
        drive(1'b1, W'(32'h77), 1'b0, 1'b1);
        chk("fullflush.count", 64'(count), 64'd0);
        chk("fullflush.overflow", 64'(overflow), 64'd0);

        // Reset mid-operation ignores a coincident write
        drive(1'b1, W'(32'h88), 1'b0, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, W'(32'h99), 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("midrst.count", 64'(count), 64'd0);
        chk("midrst.m_valid", 64'(m_valid), 64'd0);

        // BUSY_LEVEL=2 instance
        dvalid2 = 1'b1;
        din2 = W'(32'h1);
        @(posedge clk); #1;
        chk("bl2.dbusy1", 64'(dbusy2), 64'd0);
        din2 = W'(32'h2);
        @(posedge clk); #1;
        dvalid2 = 1'b0;
        chk("bl2.count", 64'(count2), 64'd2);
        chk("bl2.dbusy2", 64'(dbusy2), 64'd1);
        m_ready2 = 1'b1;
        @(posedge clk); #1;
        m_ready2 = 1'b0;
        chk("bl2.rd_dbusy", 64'(dbusy2), 64'd0);
        chk("bl2.rd_count", 64'(count2), 64'd1);
        chk("bl2.m_data", 64'(m_data2), 64'h2);

        // Randomized traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            drive(bit'($urandom_range(0, 99) < 55), W'($urandom()),
                  bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 3));
            check_all("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
